// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's burst port onto the shared RAM
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  last;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    modport master (output req, we, addr, wdata, last, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, wdata, last, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin burst arbiter sharing one single-port RAM between host and accelerator
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    ram_port_arbiter_if.slave     h,
    ram_port_arbiter_if.slave     a,
    output logic                  ram_cs,
    output logic                  ram_web,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_H = 2'd1;
    localparam logic [1:0] OWN_A = 2'd2;
    logic [1:0]    state_q, state_d;
    logic          pri_q, pri_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rd_pend_q, rd_pend_d, rd_own_q, rd_own_d;
    logic          own_h, own_a, owned, o_req, o_we, o_last, beat, done;
    // owner mux, release decision and next-state; pri 0 = host holds priority
    always_comb begin
        own_h     = state_q == OWN_H;
        own_a     = state_q == OWN_A;
        owned     = own_h | own_a;
        o_req     = own_h ? h.req : own_a & a.req;
        o_we      = own_h ? h.we : a.we;
        o_last    = own_h ? h.last : a.last;
        beat      = owned & o_req;
        cnt_inc   = cnt_q + CW'(1);
        done      = owned & (~o_req | o_last | cnt_inc == CW'(MAX_BURST));
        state_d   = done ? IDLE : owned ? state_q :
                    h.req & (~a.req | ~pri_q) ? OWN_H : a.req ? OWN_A : IDLE;
        pri_d     = done ? own_h : pri_q;
        cnt_d     = owned ? (beat ? cnt_inc : cnt_q) : '0;
        rd_pend_d = beat & ~o_we;
        rd_own_d  = own_a;
    end
    // arbitration state and read-return tracking
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            pri_q     <= 1'b0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end
    assign ram_cs      = beat;
    assign ram_web     = ~(beat & o_we);
    assign ram_address = beat ? (own_h ? h.addr : a.addr) : '0;
    assign ram_d       = beat ? (own_h ? h.wdata : a.wdata) : '0;
    assign h.gnt       = own_h;
    assign a.gnt       = own_a;
    assign h.rvalid    = rd_pend_q & ~rd_own_q;
    assign a.rvalid    = rd_pend_q & rd_own_q;
    assign h.rdata     = ram_q;
    assign a.rdata     = ram_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed timeline checks plus randomized traffic against a reference memory
module tb_ram_port_arbiter;
    localparam int DW = 64;
    localparam int AW = 16;
    localparam int MB = 16;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    logic          ram_cs, ram_web;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_d, ram_q;
    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rstb(rstb), .h(h_if), .a(a_if),
        .ram_cs(ram_cs), .ram_web(ram_web), .ram_address(ram_address),
        .ram_d(ram_d), .ram_q(ram_q)
    );
    // synchronous single-port RAM, read data one cycle after the read beat
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (!ram_web) mem[ram_address[7:0]] <= ram_d;
            else ram_q <= mem[ram_address[7:0]];
        end
    end
    logic          rq [2], we [2], ls [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          g [2], rv [2];
    logic [DW-1:0] rd [2];
    assign h_if.req = rq[0]; assign h_if.we = we[0]; assign h_if.addr = ad[0];
    assign h_if.wdata = wd[0]; assign h_if.last = ls[0];
    assign a_if.req = rq[1]; assign a_if.we = we[1]; assign a_if.addr = ad[1];
    assign a_if.wdata = wd[1]; assign a_if.last = ls[1];
    assign g[0] = h_if.gnt; assign g[1] = a_if.gnt;
    assign rv[0] = h_if.rvalid; assign rv[1] = a_if.rvalid;
    assign rd[0] = h_if.rdata; assign rd[1] = a_if.rdata;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; we[i] = 1'b0; ls[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
    endtask
    task automatic do_reset();
        rstb = 1'b0;
        idle_all();
        tick();
        tick();
        rstb = 1'b1;
    endtask
    task automatic chk_rst_outs(input string tag);
        chk({tag, " h_gnt"}, g[0], 0);
        chk({tag, " a_gnt"}, g[1], 0);
        chk({tag, " h_rvalid"}, rv[0], 0);
        chk({tag, " a_rvalid"}, rv[1], 0);
        chk({tag, " ram_cs"}, ram_cs, 0);
        chk({tag, " ram_web"}, ram_web, 1);
        chk({tag, " ram_address"}, ram_address, 0);
        chk({tag, " ram_d"}, ram_d, 0);
    endtask
    localparam logic [DW-1:0] D1 = 64'h1122334455667788;
    int hb, ab;
    int run [2];
    int rem [2];
    logic use_last [2], bt [2], prv [2], pkn [2], plast [2], pg [2];
    logic [DW-1:0] pexp [2];
    logic [DW-1:0] refm [0:31];
    logic          kn [0:31];
    initial begin
        idle_all();
        do_reset();
        @(negedge clk);
        chk_rst_outs("reset");
        // host single write then single read
        tick();
        rq[0] = 1; we[0] = 1; ad[0] = 16'h0010; wd[0] = D1; ls[0] = 1;
        @(negedge clk);
        chk("t1 pre gnt", g[0], 0);
        chk("t1 pre cs", ram_cs, 0);
        tick();
        @(negedge clk);
        chk("t1 wr gnt", g[0], 1);
        chk("t1 wr cs", ram_cs, 1);
        chk("t1 wr web", ram_web, 0);
        chk("t1 wr addr", ram_address, 16'h0010);
        chk("t1 wr d", ram_d, D1);
        tick();
        we[0] = 0; wd[0] = '0;
        @(negedge clk);
        chk("t1 gap gnt", g[0], 0);
        chk("t1 gap cs", ram_cs, 0);
        chk("t1 gap web", ram_web, 1);
        chk("t1 no wr rvalid", rv[0], 0);
        tick();
        @(negedge clk);
        chk("t1 rd gnt", g[0], 1);
        chk("t1 rd cs", ram_cs, 1);
        chk("t1 rd web", ram_web, 1);
        chk("t1 rd addr", ram_address, 16'h0010);
        tick();
        rq[0] = 0;
        @(negedge clk);
        chk("t1 h_rvalid", rv[0], 1);
        chk("t1 h_rdata", rd[0], D1);
        chk("t1 a_rvalid", rv[1], 0);
        chk("t1 gnt off", g[0], 0);
        tick();
        @(negedge clk);
        chk("t1 h_rvalid end", rv[0], 0);
        // both request 4-beat reads from reset: host first, one idle cycle, then accelerator
        do_reset();
        hb = 0; ab = 0;
        rq[0] = 1; rq[1] = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("t2 h_gnt c%0d", c), g[0], c >= 1 && c <= 4);
            chk($sformatf("t2 a_gnt c%0d", c), g[1], c >= 6 && c <= 9);
            chk($sformatf("t2 h_rv c%0d", c), rv[0], c >= 2 && c <= 5);
            chk($sformatf("t2 a_rv c%0d", c), rv[1], c >= 7 && c <= 10);
            if (g[0] && rq[0]) hb++;
            if (g[1] && rq[1]) ab++;
            tick();
            rq[0] = hb < 4; ls[0] = hb == 3; ad[0] = AW'(hb);
            rq[1] = ab < 4; ls[1] = ab == 3; ad[1] = AW'(ab + 8);
        end
        // accelerator streams 20 beats without last; forced release lets pending host in
        do_reset();
        hb = 0; ab = 0;
        rq[1] = 1; we[1] = 1; ls[1] = 0;
        we[0] = 1; ls[0] = 1;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            chk($sformatf("t3 a_gnt c%0d", c), g[1], (c >= 1 && c <= 16) || (c >= 20 && c <= 24));
            chk($sformatf("t3 h_gnt c%0d", c), g[0], c == 18);
            chk($sformatf("t3 cs c%0d", c), ram_cs, (c >= 1 && c <= 16) || c == 18 || (c >= 20 && c <= 23));
            if (g[0] && rq[0]) hb++;
            if (g[1] && rq[1]) ab++;
            tick();
            rq[1] = ab < 20; ad[1] = AW'(ab); wd[1] = DW'(ab);
            rq[0] = c + 1 >= 2 && hb < 1;
        end
        // host abandons after 3 beats; priority flips to the accelerator
        do_reset();
        hb = 0; ab = 0;
        rq[0] = 1; rq[1] = 1; ls[1] = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("t4 h_gnt c%0d", c), g[0], (c >= 1 && c <= 4) || c == 8);
            chk($sformatf("t4 a_gnt c%0d", c), g[1], c == 6);
            chk($sformatf("t4 cs c%0d", c), ram_cs, (c >= 1 && c <= 3) || c == 6 || c == 8);
            if (g[0] && rq[0]) hb++;
            if (g[1] && rq[1]) ab++;
            tick();
            rq[0] = c + 1 != 4 && hb < 4;
            ls[0] = c + 1 >= 5;
            rq[1] = ab < 1;
        end
        // reset pulse during a read burst with data in flight
        do_reset();
        rq[0] = 1; we[0] = 0; ls[0] = 0; ad[0] = 16'h0010;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t5 gnt", g[0], 1);
        tick();
        @(negedge clk);
        chk("t5 rvalid before", rv[0], 1);
        rstb = 1'b0;
        #1;
        chk_rst_outs("t5 async");
        tick();
        rstb = 1'b1;
        rq[0] = 0;
        @(negedge clk);
        chk("t5 rvalid after", rv[0], 0);
        chk("t5 gnt after", g[0], 0);
        chk("t5 cs after", ram_cs, 0);
        tick();
        @(negedge clk);
        chk("t5 rvalid later", rv[0], 0);
        // randomized traffic against a reference memory
        do_reset();
        for (int i = 0; i < 32; i++) begin
            refm[i] = '0;
            kn[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; rem[i] = 0; use_last[i] = 0;
            prv[i] = 0; pkn[i] = 0; plast[i] = 0; pg[i] = 0; pexp[i] = '0;
        end
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            chk("rnd excl", g[0] & g[1], 0);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd rvalid%0d", i), rv[i], prv[i]);
                if (prv[i] && pkn[i]) chk($sformatf("rnd rdata%0d", i), rd[i], pexp[i]);
                run[i] = g[i] ? run[i] + 1 : 0;
                chk($sformatf("rnd burst%0d", i), run[i] <= MB, 1);
                chk($sformatf("rnd gap%0d", i), g[i] & pg[1-i], 0);
                chk($sformatf("rnd lastrel%0d", i), g[i] & plast[i], 0);
            end
            for (int i = 0; i < 2; i++) pg[i] = g[i];
            for (int i = 0; i < 2; i++) begin
                bt[i] = g[i] & rq[i];
                prv[i] = bt[i] & ~we[i];
                plast[i] = bt[i] & ls[i];
                if (bt[i] && we[i]) begin
                    refm[ad[i][4:0]] = wd[i];
                    kn[ad[i][4:0]] = 1'b1;
                end else if (bt[i]) begin
                    pexp[i] = refm[ad[i][4:0]];
                    pkn[i] = kn[ad[i][4:0]];
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                if (bt[i]) rem[i] = ls[i] ? 0 : rem[i] - 1;
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    rem[i] = $urandom_range(1, 20);
                    use_last[i] = $urandom_range(0, 3) != 0;
                end else if (rem[i] > 0 && $urandom_range(0, 49) == 0) begin
                    rem[i] = 0;
                end
                rq[i] = rem[i] > 0;
                we[i] = $urandom_range(0, 1) == 1;
                ad[i] = AW'($urandom_range(0, 31));
                wd[i] = {$urandom, $urandom};
                ls[i] = use_last[i] && rem[i] == 1;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (64-bit data, 16-bit address, active-low write enable, chip select) between the host loader and the matrix accelerator. It grants ownership in bursts using round-robin priority and caps each burst at MAX_BURST beats. It drives the RAM port cycle by cycle and returns read data to whichever requester issued the read, tagged by a valid strobe. It sits between the host/accelerator and the input RAM, replacing the direct accelerator-to-RAM wiring.

## Interface
- DATA_WIDTH, 64, data width of RAM and both requester ports
- ADDR_WIDTH, 16, address width
- MAX_BURST, 16, maximum beats per grant (≥1)

- clk  in  1  clock, all logic on rising edge
- rstb  in  1  asynchronous active-low reset
- h_req / a_req  in  1  host / accelerator request; one beat per cycle while high and granted
- h_we / a_we  in  1  1 = write beat, 0 = read beat
- h_addr / a_addr  in  ADDR_WIDTH  beat address
- h_wdata / a_wdata  in  DATA_WIDTH  write data
- h_last / a_last  in  1  marks final beat of burst
- h_gnt / a_gnt  out  1  requester owns the RAM port this cycle
- h_rvalid / a_rvalid  out  1  read data valid for that requester
- h_rdata / a_rdata  out  DATA_WIDTH  read data; equals ram_q, meaningful only with rvalid
- ram_cs  out  1  RAM chip select, 1 on a beat
- ram_web  out  1  RAM write enable, active low
- ram_address  out  ADDR_WIDTH  RAM address
- ram_d  out  DATA_WIDTH  RAM write data
- ram_q  in  DATA_WIDTH  RAM read data, valid one cycle after read beat

## Operation
- States: IDLE, OWN_H, OWN_A. h_gnt = (state==OWN_H); a_gnt = (state==OWN_A); both registered-state decodes, never both high.
- Beat: cycle where owner's req=1 while in its OWN state. Beat drives ram_cs=1, ram_web=~we, ram_address/ram_d from owner. Non-beat cycles: ram_cs=0, ram_web=1, ram_address=0, ram_d=0.
- IDLE: if only one req high, go to its OWN state; if both high, go to the one holding priority (rr_pri); neither, stay.
- OWN_x → IDLE when any of: beat with last=1; owner req=0 (abandon, no beat); beat count reaches MAX_BURST (forced release, even without last). Otherwise stay.
- On leaving OWN_x, rr_pri points to the other requester. Always one IDLE cycle between grants.
- Beat counter cleared on entry to OWN state, +1 per beat, width clog2(MAX_BURST)+1; no wrap.
- Read return: registered rd_pending/rd_owner; cycle after a read beat, owner's rvalid=1. Writes produce no rvalid. Back-to-back reads give continuous rvalid.
- Requester ignoring a dropped gnt mid-burst must re-request; arbiter keeps no burst state across grants.

## Timing
- Reset (async assert, sync deassert expected): state=IDLE, rr_pri=host, beat count=0, h_gnt=a_gnt=0, h_rvalid=a_rvalid=0, ram_cs=0, ram_web=1, ram_address=0, ram_d=0.
- Latency: req seen in IDLE at cycle N → gnt high N+1 → first beat N+1 → first rvalid N+2.
- Burst of k≤MAX_BURST beats with last on beat k: gnt high exactly k cycles, low the next cycle (IDLE).
- Simultaneous first requests after reset: host wins.
- Reset mid-burst: grant and in-flight rvalid dropped immediately; no RAM beat in reset.
- req changing while not granted has no effect on RAM outputs.

## Test plan
- Host single write addr 0x0010 data 0x1122334455667788 then single read: ram_web low one cycle at grant cycle; h_rvalid one cycle later with h_rdata=0x1122334455667788; a_rvalid stays 0.
- Both req high from reset, 4-beat reads each: host granted cycles 1-4, IDLE cycle 5, accelerator cycles 6-9; rvalids trail each beat by one cycle.
- Accelerator holds req for 20 beats without last, MAX_BURST=16: a_gnt drops after 16 beats; host (pending) granted after IDLE; accelerator regranted afterwards.
- Owner drops req mid-burst after 3 beats: gnt drops next cycle, no extra RAM beat, rr_pri flips.
- rstb pulsed low during burst with read in flight: all outputs go to reset values asynchronously; no rvalid after release.
- Random traffic 10k cycles vs. reference RAM model: every read returns last written value, gnts mutually exclusive, no burst exceeds MAX_BURST.
